// File: rtl/y_mux2_if.sv
// rtl/y_mux2_if.sv - Signal bundle for one y_mux2 instance (select inputs plus plain and registered results).
interface y_mux2_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic [WIDTH-1:0] z;
    logic [WIDTH-1:0] z_q;
    logic             z_chg;

    modport master (output a, output b, output c, input z, input z_q, input z_chg);
    modport slave  (input a, input b, input c, output z, output z_q, output z_chg);
endinterface

// File: rtl/y_mux2.sv
// rtl/y_mux2.sv - Bit-sliced WIDTH-bit 2:1 mux; Y_MUX2_REG_OUT_EN adds a registered copy of z with a change pulse.
// Port order keeps z, a, b, c first so four-port positional instances stay legal.
module y_mux2 #(
    parameter int WIDTH = 2
) (
    output logic [WIDTH-1:0] z,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] z_q,
    output logic             z_chg
);

    // The a&b consensus term lets bits with a==b resolve even when c is X or Z.
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        assign z[i] = (a[i] & c) | (b[i] & ~c) | (a[i] & b[i]);
    end

`ifdef Y_MUX2_REG_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q   <= '0;
            z_chg <= 1'b0;
        end else begin
            z_chg <= (z != z_q);
            z_q   <= z;
        end
    end
`else
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst_n;
    assign z_q            = '0;
    assign z_chg          = 1'b0;
`endif

endmodule

// File: tb/tb_y_mux2.sv
// tb/tb_y_mux2.sv - Self-checking bench for y_mux2 at WIDTH=2 and WIDTH=8 against a behavioural model.
module tb_y_mux2;

`ifdef Y_MUX2_REG_OUT_EN
    localparam bit REG_EN = 1'b1;
`else
    localparam bit REG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic clk_run = 1'b0;
    logic rst_n;
    int   n_pass = 0;
    int   n_total = 0;

    logic [1:0] exp_zq2;
    logic       exp_chg2;
    logic [7:0] exp_zq8;
    logic       exp_chg8;

    y_mux2_if #(.WIDTH(2)) bus2 ();
    y_mux2_if #(.WIDTH(8)) bus8 ();

    y_mux2 #(.WIDTH(2)) dut2 (
        .z(bus2.z), .a(bus2.a), .b(bus2.b), .c(bus2.c),
        .clk(clk), .rst_n(rst_n), .z_q(bus2.z_q), .z_chg(bus2.z_chg)
    );

    y_mux2 #(.WIDTH(8)) dut8 (
        .z(bus8.z), .a(bus8.a), .b(bus8.b), .c(bus8.c),
        .clk(clk), .rst_n(rst_n), .z_q(bus8.z_q), .z_chg(bus8.z_chg)
    );

    always #5 clk = clk_run ? ~clk : 1'b0;

    // Reference select: a when c is 1, b when 0, otherwise only agreeing bits are known.
    function automatic logic [63:0] ref_mux(input logic [63:0] a, input logic [63:0] b, input logic c);
        logic [63:0] r;
        if (c === 1'b1) r = a;
        else if (c === 1'b0) r = b;
        else begin
            for (int i = 0; i < 64; i++) r[i] = (a[i] === b[i]) ? a[i] : 1'bx;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [1:0] ref2();
        logic [63:0] r;
        r = ref_mux(64'(bus2.a), 64'(bus2.b), bus2.c);
        return r[1:0];
    endfunction

    function automatic logic [7:0] ref8();
        logic [63:0] r;
        r = ref_mux(64'(bus8.a), 64'(bus8.b), bus8.c);
        return r[7:0];
    endfunction

    // Advance one rising edge, predicting the registered outputs from the inputs present at the edge.
    task automatic tick();
        logic [1:0] n2;
        logic [7:0] n8;
        n2 = ref2();
        n8 = ref8();
        if (REG_EN && rst_n === 1'b1) begin
            exp_chg2 = (n2 != exp_zq2);
            exp_zq2  = n2;
            exp_chg8 = (n8 != exp_zq8);
            exp_zq8  = n8;
        end else begin
            exp_zq2 = '0; exp_chg2 = 1'b0;
            exp_zq8 = '0; exp_chg8 = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_zq2"},  64'(bus2.z_q),   64'(exp_zq2));
        check({tag, "_chg2"}, 64'(bus2.z_chg), 64'(exp_chg2));
        check({tag, "_zq8"},  64'(bus8.z_q),   64'(exp_zq8));
        check({tag, "_chg8"}, 64'(bus8.z_chg), 64'(exp_chg8));
    endtask

    initial begin
        rst_n = 1'b0;
        exp_zq2 = '0; exp_chg2 = 1'b0; exp_zq8 = '0; exp_chg8 = 1'b0;
        bus2.a = '0; bus2.b = '0; bus2.c = 1'b0;
        bus8.a = '0; bus8.b = '0; bus8.c = 1'b0;
        #1;
        check_regs("reset_state");

        // Exhaustive WIDTH=2 sweep, no clock running.
        for (int av = 0; av < 4; av++) begin
            for (int bv = 0; bv < 4; bv++) begin
                for (int cv = 0; cv < 2; cv++) begin
                    bus2.a = 2'(av); bus2.b = 2'(bv); bus2.c = 1'(cv);
                    #20;
                    check("sweep_z", 64'(bus2.z), 64'(cv == 1 ? av : bv));
                end
            end
        end

        // Select toggle with no clock.
        bus2.a = 2'b10; bus2.b = 2'b01;
        bus2.c = 1'b0; #20; check("toggle_c0", 64'(bus2.z), 64'(2'b01));
        bus2.c = 1'b1; #20; check("toggle_c1", 64'(bus2.z), 64'(2'b10));
        bus2.c = 1'b0; #20; check("toggle_c0b", 64'(bus2.z), 64'(2'b01));

        // Unknown select: agreeing bits resolve, the rest go X.
        bus2.c = 1'bx;
        for (int av = 0; av < 4; av++) begin
            bus2.a = 2'(av); bus2.b = 2'(3 - av);
            #20; check("x_sel_diff", 64'(bus2.z), 64'(ref2()));
            bus2.b = 2'(av);
            #20; check("x_sel_same", 64'(bus2.z), 64'(ref2()));
        end
        bus2.c = 1'b0;

        // Width scaling.
        bus8.a = 8'hA5; bus8.b = 8'h5A;
        bus8.c = 1'b1; #20; check("w8_c1", 64'(bus8.z), 64'(8'hA5));
        bus8.c = 1'b0; #20; check("w8_c0", 64'(bus8.z), 64'(8'h5A));
        for (int k = 0; k < 16; k++) begin
            bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.c = 1'($urandom);
            #20; check("w8_rand", 64'(bus8.z), 64'(ref8()));
        end
        check_regs("still_reset");

        // Registered latency after reset release.
        bus2.a = 2'd3; bus2.b = 2'd0; bus2.c = 1'b1;
        bus8.a = 8'd3; bus8.b = 8'd0; bus8.c = 1'b1;
        #1;
        rst_n = 1'b1;
        clk_run = 1'b1;
        tick();
        check("lat_edge1_zq", 64'(bus2.z_q), REG_EN ? 64'd3 : 64'd0);
        check("lat_edge1_chg", 64'(bus2.z_chg), REG_EN ? 64'd1 : 64'd0);
        check("lat_edge1_z", 64'(bus2.z), 64'd3);
        check_regs("lat_edge1");
        tick();
        check("lat_edge2_zq", 64'(bus2.z_q), REG_EN ? 64'd3 : 64'd0);
        check("lat_edge2_chg", 64'(bus2.z_chg), 64'd0);
        check_regs("lat_edge2");

        // Random clocked run; inputs sometimes held to exercise no-change cycles.
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) != 0) begin
                bus2.a = 2'($urandom); bus2.b = 2'($urandom); bus2.c = 1'($urandom);
                bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.c = 1'($urandom);
            end
            #1;
            check("rand_z2", 64'(bus2.z), 64'(ref2()));
            check("rand_z8", 64'(bus8.z), 64'(ref8()));
            tick();
            check_regs("rand");
        end

        // Asynchronous reset between edges with z_q holding 11.
        bus2.a = 2'd3; bus2.c = 1'b1;
        bus8.a = 8'hFF; bus8.c = 1'b1;
        tick();
        tick();
        check("pre_rst_zq", 64'(bus2.z_q), REG_EN ? 64'd3 : 64'd0);
        #2;
        rst_n = 1'b0;
        exp_zq2 = '0; exp_chg2 = 1'b0; exp_zq8 = '0; exp_chg8 = 1'b0;
        #1;
        check_regs("async_rst");
        check("async_rst_z", 64'(bus2.z), 64'd3);
        tick();
        check_regs("rst_held");

        // Release with z nonzero: first capture pulses z_chg.
        #2;
        rst_n = 1'b1;
        tick();
        check("rel_nz_chg", 64'(bus2.z_chg), REG_EN ? 64'd1 : 64'd0);
        check_regs("rel_nz");

        // Release with z zero: first capture does not pulse.
        #2;
        rst_n = 1'b0;
        bus2.a = '0; bus2.b = '0; bus8.a = '0; bus8.b = '0;
        exp_zq2 = '0; exp_chg2 = 1'b0; exp_zq8 = '0; exp_chg8 = 1'b0;
        #1;
        check_regs("rst2");
        rst_n = 1'b1;
        tick();
        check("rel_z0_chg", 64'(bus2.z_chg), 64'd0);
        check_regs("rel_z0");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
